// File: rtl/dct_block_sequencer.sv
// Sequences one 8x8 forward DCT: for each of the 64 coefficients it streams all 64
// pixels through a multiply-accumulate and emits the rounded result on a valid/ready port.
module dct_block_sequencer #(
    parameter int FRAC_BITS = 10,
    parameter int PIX_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    pix_rd,
    output logic [5:0]              pix_addr,
    input  logic signed [PIX_W-1:0] pix_data,
    output logic [2:0]              lut_k1,
    output logic [2:0]              lut_k2,
    output logic [2:0]              lut_n1,
    output logic [2:0]              lut_n2,
    input  logic signed [31:0]      cos_term,
    output logic signed [31:0]      coeff_out,
    output logic [5:0]              coeff_idx,
    output logic                    coeff_valid,
    input  logic                    coeff_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, OUT} state_t;

    localparam logic signed [31:0] HALF = 32'sd1 <<< (FRAC_BITS - 1);

    state_t             state_q, state_d;
    logic [5:0]         k_q, k_d;
    logic [5:0]         n_q, n_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [31:0] cos_q, cos_d;
    logic               mac_en_q, mac_en_d;
    logic               mac_first_q, mac_first_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pix_rd_q, pix_rd_d;
    logic               coeff_valid_q, coeff_valid_d;
    logic signed [31:0] coeff_out_q, coeff_out_d;
    logic signed [31:0] prod;
    logic signed [31:0] rounded;

    // Low 32 bits of the full-width product equal the product of 32-bit sign-extended operands.
    assign prod = 32'(pix_data) * cos_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        k_d           = k_q;
        n_d           = n_q;
        acc_d         = acc_q;
        cos_d         = cos_q;
        pix_rd_d      = 1'b0;
        done_d        = 1'b0;
        coeff_valid_d = 1'b0;
        coeff_out_d   = coeff_out_q;
        mac_en_d      = pix_rd_q;
        mac_first_d   = (n_q == 6'd0);

        // MAC stage works on the read issued one cycle earlier.
        if (mac_en_q) begin
            acc_d = mac_first_q ? prod : acc_q + prod;
        end
        if (pix_rd_q) begin
            cos_d = cos_term;
        end
        rounded = (acc_d + HALF) >>> FRAC_BITS;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ACCUM;
                    k_d      = 6'd0;
                    n_d      = 6'd0;
                    pix_rd_d = 1'b1;
                end
            end
            ACCUM: begin
                if (n_q == 6'd63) begin
                    state_d = FLUSH;
                end else begin
                    n_d      = n_q + 6'd1;
                    pix_rd_d = 1'b1;
                end
            end
            FLUSH: begin
                state_d       = OUT;
                coeff_valid_d = 1'b1;
                coeff_out_d   = rounded;
            end
            OUT: begin
                coeff_valid_d = 1'b1;
                if (coeff_ready) begin
                    coeff_valid_d = 1'b0;
                    if (k_q == 6'd63) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ACCUM;
                        k_d      = k_q + 6'd1;
                        n_d      = 6'd0;
                        pix_rd_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d       = IDLE;
            n_d           = 6'd0;
            pix_rd_d      = 1'b0;
            coeff_valid_d = 1'b0;
            done_d        = 1'b0;
            mac_en_d      = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_q           <= 6'd0;
            n_q           <= 6'd0;
            acc_q         <= 32'sd0;
            cos_q         <= 32'sd0;
            mac_en_q      <= 1'b0;
            mac_first_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pix_rd_q      <= 1'b0;
            coeff_valid_q <= 1'b0;
            coeff_out_q   <= 32'sd0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            n_q           <= n_d;
            acc_q         <= acc_d;
            cos_q         <= cos_d;
            mac_en_q      <= mac_en_d;
            mac_first_q   <= mac_first_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pix_rd_q      <= pix_rd_d;
            coeff_valid_q <= coeff_valid_d;
            coeff_out_q   <= coeff_out_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pix_rd      = pix_rd_q;
    assign pix_addr    = n_q;
    assign lut_n1      = n_q[5:3];
    assign lut_n2      = n_q[2:0];
    assign lut_k1      = k_q[5:3];
    assign lut_k2      = k_q[2:0];
    assign coeff_valid = coeff_valid_q;
    assign coeff_out   = coeff_out_q;
    assign coeff_idx   = k_q;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Bench for dct_block_sequencer: behavioural pixel RAM and cosine LUT, dot-product
// reference model, randomized pixels and backpressure, directed corner cases.
module tb_dct_block_sequencer;

    localparam int FRAC_BITS = 10;
    localparam int PIX_W     = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    logic                    coeff_ready = 1'b1;
    logic                    busy, done, pix_rd, coeff_valid;
    logic [5:0]              pix_addr, coeff_idx;
    logic [2:0]              lut_k1, lut_k2, lut_n1, lut_n2;
    logic signed [PIX_W-1:0] pix_data = '0;
    logic signed [31:0]      cos_term, coeff_out;

    int                      lut_tbl [4096];
    logic signed [7:0]       pix_mem [64];
    bit                      stub_mode = 1'b0;
    int                      stub_val = 0;

    int n_tests = 0;
    int n_fail  = 0;

    int got_c[$];
    int got_i[$];
    int exp_c [64];
    int done_cyc, n_rd, n_done, lut_bad, stall_bad, stall_total, post_abort_bad;
    int busy_c1, rd_c1, addr_c1, busy_done, busy_after_abort;

    dct_block_sequencer #(.FRAC_BITS(FRAC_BITS), .PIX_W(PIX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .pix_rd     (pix_rd),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .lut_k1     (lut_k1),
        .lut_k2     (lut_k2),
        .lut_n1     (lut_n1),
        .lut_n2     (lut_n2),
        .cos_term   (cos_term),
        .coeff_out  (coeff_out),
        .coeff_idx  (coeff_idx),
        .coeff_valid(coeff_valid),
        .coeff_ready(coeff_ready)
    );

    always #5 clk = ~clk;

    // Synchronous pixel RAM: data appears the cycle after the read strobe.
    always @(posedge clk) if (pix_rd) pix_data <= pix_mem[pix_addr];

    assign cos_term = stub_mode ? stub_val : lut_tbl[{lut_k1, lut_k2, lut_n1, lut_n2}];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cos_at(input int k, input int n);
        return stub_mode ? stub_val : lut_tbl[k * 64 + n];
    endfunction

    // X(k1,k2) = round(sum_n pixel[n] * C(k,n) / 2^FRAC_BITS), 32-bit wrapping arithmetic.
    task automatic compute_model();
        for (int k = 0; k < 64; k++) begin
            int acc = 0;
            for (int n = 0; n < 64; n++) acc += int'(pix_mem[n]) * cos_at(k, n);
            exp_c[k] = (acc + (1 << (FRAC_BITS - 1))) >>> FRAC_BITS;
        end
    endtask

    task automatic fill_lut();
        real pi = 3.14159265358979323846;
        for (int k1 = 0; k1 < 8; k1++)
            for (int k2 = 0; k2 < 8; k2++)
                for (int n1 = 0; n1 < 8; n1++)
                    for (int n2 = 0; n2 < 8; n2++) begin
                        real a1 = (k1 == 0) ? $sqrt(0.125) : 0.5;
                        real a2 = (k2 == 0) ? $sqrt(0.125) : 0.5;
                        real r = 1024.0 * a1 * a2 * $cos((2 * n1 + 1) * k1 * pi / 16.0)
                                 * $cos((2 * n2 + 1) * k2 * pi / 16.0);
                        lut_tbl[k1 * 512 + k2 * 64 + n1 * 8 + n2] = $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
                    end
    endtask

    // mode 0: always ready, 1: ten-cycle stall at coeff_idx 5, 2: random ready.
    task automatic run_block(input int mode, input int start_again, input int abort_cyc,
                             input int reset_cyc, input int budget);
        int stalled = 0;
        bit was_stalling = 1'b0;
        logic signed [31:0] hold_out = '0;
        logic [5:0] hold_idx = '0;
        got_c.delete(); got_i.delete();
        done_cyc = -1; n_rd = 0; n_done = 0; lut_bad = 0; stall_bad = 0; stall_total = 0;
        post_abort_bad = 0; busy_c1 = 0; rd_c1 = 0; addr_c1 = -1; busy_done = -1; busy_after_abort = -1;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = (cyc == start_again);
            abort = (abort_cyc > 0 && cyc == abort_cyc);
            if (cyc == reset_cyc) begin
                rst_n = 1'b0;
                #1;
                check("rst_async_busy", busy, 0);
                check("rst_async_done", done, 0);
                check("rst_async_pix_rd", pix_rd, 0);
                check("rst_async_valid", coeff_valid, 0);
                check("rst_async_addr", pix_addr, 0);
                check("rst_async_lut_k", {lut_k1, lut_k2}, 0);
                check("rst_async_coeff", coeff_out, 0);
                check("rst_async_idx", coeff_idx, 0);
                break;
            end
            case (mode)
                1: if (coeff_valid && coeff_idx == 6'd5 && stalled < 10) begin
                       coeff_ready = 1'b0;
                       stalled++;
                   end else coeff_ready = 1'b1;
                2: coeff_ready = ($urandom_range(0, 3) != 0);
                default: coeff_ready = 1'b1;
            endcase
            if (was_stalling && (!coeff_valid || coeff_out !== hold_out || coeff_idx !== hold_idx))
                stall_bad++;
            if (coeff_valid && !coeff_ready) begin
                stall_total++;
                if (pix_rd) stall_bad++;
            end
            was_stalling = coeff_valid && !coeff_ready;
            hold_out = coeff_out;
            hold_idx = coeff_idx;
            if (pix_rd) begin
                n_rd++;
                if (lut_n1 !== pix_addr[5:3] || lut_n2 !== pix_addr[2:0]) lut_bad++;
            end
            if (coeff_valid && coeff_ready) begin
                got_c.push_back(coeff_out);
                got_i.push_back(coeff_idx);
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc  = cyc;
                    busy_done = busy;
                end
            end
            if (cyc == 1) begin
                busy_c1 = busy;
                rd_c1   = pix_rd;
                addr_c1 = pix_addr;
            end
            if (abort_cyc > 0 && cyc == abort_cyc + 1) busy_after_abort = busy;
            if (abort_cyc > 0 && cyc > abort_cyc && (coeff_valid || done || pix_rd || busy)) post_abort_bad++;
            if (abort_cyc > 0 && cyc >= abort_cyc + 20) break;
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
        end
        start = 1'b0;
        abort = 1'b0;
        coeff_ready = 1'b1;
    endtask

    task automatic check_block(input string tag, input int exp_done);
        check({tag, "_ncoeff"}, got_c.size(), 64);
        for (int i = 0; i < got_c.size() && i < 64; i++) begin
            check($sformatf("%s_idx%0d", tag, i), got_i[i], i);
            check($sformatf("%s_coeff%0d", tag, i), got_c[i], exp_c[i]);
        end
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_busy_at_done"}, busy_done, 0);
        check({tag, "_pix_rd_count"}, n_rd, 4096);
        check({tag, "_lut_n_match"}, lut_bad, 0);
        check({tag, "_stall_hold"}, stall_bad, 0);
        check({tag, "_busy_c1"}, busy_c1, 1);
        check({tag, "_pix_rd_c1"}, rd_c1, 1);
        check({tag, "_addr_c1"}, addr_c1, 0);
    endtask

    task automatic random_pixels();
        for (int n = 0; n < 64; n++) pix_mem[n] = 8'($urandom);
    endtask

    initial begin
        fill_lut();
        for (int n = 0; n < 64; n++) pix_mem[n] = '0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pix_rd", pix_rd, 0);
        check("reset_valid", coeff_valid, 0);
        check("reset_addr", pix_addr, 0);
        check("reset_coeff", coeff_out, 0);
        check("reset_idx", coeff_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero pixels
        compute_model();
        run_block(0, 0, 0, 0, 4400);
        check_block("zero", 4225);

        // Constant pixel 10 with the real LUT
        for (int n = 0; n < 64; n++) pix_mem[n] = 8'sd10;
        compute_model();
        run_block(0, 0, 0, 0, 4400);
        check("const_dc", got_c.size() > 0 ? got_c[0] : -1, 80);
        check_block("const", 4225);

        // Random pixels with random backpressure
        random_pixels();
        compute_model();
        run_block(2, 0, 0, 0, 9000);
        check_block("rand_bp", 4225 + stall_total);

        // Ten-cycle stall at coeff_idx 5
        random_pixels();
        compute_model();
        run_block(1, 0, 0, 0, 4400);
        check_block("stall10", 4235);
        check("stall10_cycles", stall_total, 10);

        // Rounding with a flat 0.5 LUT
        stub_mode = 1'b1;
        stub_val  = 512;
        for (int n = 0; n < 64; n++) pix_mem[n] = '0;
        pix_mem[0] = 8'sd127;
        compute_model();
        run_block(0, 0, 0, 0, 4400);
        check("round127_first", got_c.size() > 0 ? got_c[0] : -1, 64);
        check("round127_last", got_c.size() > 63 ? got_c[63] : -1, 64);
        check_block("round127", 4225);
        pix_mem[0] = -8'sd1;
        compute_model();
        run_block(0, 0, 0, 0, 4400);
        check("round_m1_first", got_c.size() > 0 ? got_c[0] : -1, 0);
        check_block("round_m1", 4225);
        stub_mode = 1'b0;

        // start while busy is ignored
        random_pixels();
        compute_model();
        run_block(0, 30, 0, 0, 4400);
        check_block("start_busy", 4225);

        // Abort in C100, then a clean block
        run_block(0, 0, 100, 0, 400);
        check("abort_busy_c101", busy_after_abort, 0);
        check("abort_quiet_after", post_abort_bad, 0);
        check("abort_coeffs_before", got_c.size(), 1);
        check("abort_no_done", n_done, 0);
        run_block(0, 0, 0, 0, 4400);
        check_block("after_abort", 4225);

        // Asynchronous reset mid-block
        run_block(0, 0, 0, 2000, 2100);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_block_sequencer.md
# dct_block_sequencer

Sequences one full 8x8 forward DCT. It walks all 64 coefficient indices (k1,k2). For each index it reads all 64 pixels (n1,n2) from the block buffer and presents (k1,k2,n1,n2) to the per-coefficient cosine LUT bank. It multiplies each pixel by the returned signed Q.FRAC_BITS cosine term (which already carries both alpha normalisations) and accumulates the result. It sits between the pixel block RAM and the coefficient FIFO feeding quantisation.

## Interface
- FRAC_BITS, 10: fractional bits of cos_term (1.0 = 1024).
- PIX_W, 8: pixel width, signed, level-shifted (-128..127).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset (one clock; reset asynchronous active-low, fixed).
- start  in  1  begin a block; sampled only in IDLE.
- abort  in  1  synchronous abandon; returns to IDLE next cycle.
- busy  out  1  high from the cycle after start acceptance until IDLE.
- done  out  1  one-cycle pulse after the 64th coefficient handshake.
- pix_rd  out  1  pixel read strobe.
- pix_addr  out  6  {n1,n2}, row-major.
- pix_data  in  PIX_W  signed; valid the cycle after pix_rd (synchronous RAM).
- lut_k1, lut_k2  out  3 each  coefficient index selecting the LUT.
- lut_n1, lut_n2  out  3 each  equal to pix_addr[5:3], pix_addr[2:0].
- cos_term  in  32  signed, combinational from the LUT bank.
- coeff_out  out  32  signed rounded coefficient.
- coeff_idx  out  6  {k1,k2} of coeff_out.
- coeff_valid  out  1  coefficient available.
- coeff_ready  in  1  downstream accepts.

## Operation
- **States:** IDLE, ACCUM, FLUSH, OUT.
- **IDLE:**
  - On start=1, clear k to 0 and n to 0, then go to ACCUM.
  - start is ignored in every other state.
- **ACCUM:**
  - Each cycle asserts pix_rd=1, pix_addr=n, lut_n=n, lut_k=k.
  - Registers cos_term into cos_q, then increments n.
  - After n=63 is issued, go to FLUSH.
- **MAC (one cycle behind issue):**
  - prod = sext(pix_data) × cos_q, computed at full width and truncated to 32 bits.
  - For n=0: acc ← prod. For n>0: acc ← acc + prod.
  - acc is 32-bit signed and wraps, with no saturation.
- **FLUSH:** performs the n=63 accumulate with pix_rd=0, then goes to OUT.
- **OUT:**
  - coeff_valid=1, coeff_out = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, round half up), coeff_idx=k.
  - coeff_out and coeff_idx stay stable while coeff_ready=0.
  - On coeff_valid & coeff_ready:
    - If k<63: increment k (k1 outer, k2 inner), reset n to 0, go to ACCUM.
    - If k=63: go to IDLE and pulse done.
- **abort:** high in any non-IDLE state forces IDLE on the next edge. No done pulse; coeff_valid drops; acc contents are don't-care.
- **Reset values** (while rst_n=0, asynchronous):
  - State IDLE, k=0, n=0, acc=0, cos_q=0.
  - Outputs busy, done, pix_rd, coeff_valid = 0.
  - pix_addr, lut_* = 0; coeff_out = 0, coeff_idx = 0.
  - Reset mid-block discards the block.

## Timing
- **Block start:** start is high at edge E0. Cycles C1..C64 are ACCUM, issuing n=0..63; busy=1 from C1.
- **Per coefficient:**
  - C65 is FLUSH.
  - C66 is OUT with coeff_valid=1.
  - With coeff_ready high in C66, the next ACCUM begins in C67.
  - Minimum per coefficient is 66 cycles.
- **Full block:** 4224 cycles with no backpressure. done=1 and busy=0 in C4225.
- **Backpressure:** each cycle of coeff_ready=0 during OUT adds exactly one cycle. No pix_rd is issued while stalled.
- **Handshake:** coeff_valid never drops without a handshake, except on abort or reset.
- **start at completion:** start asserted in the same cycle as done is accepted, because the state is IDLE.

## Test plan
- **All-zero pixels:** 64 coefficients, all 0, with coeff_idx 0..63 in order. done is seen in C4225 and exactly 4096 pix_rd pulses occur.
- **Constant pixel 10, real LUT bank:** coeff_idx 0 gives coeff_out=80 (64×10×128 = 81920 >>10). Every other coefficient matches a bit-exact software model using the same LUT tables.
- **Backpressure:** hold coeff_ready=0 for 10 cycles at coeff_idx 5. coeff_out and coeff_idx stay stable, no pix_rd occurs while stalled, and done arrives in C4235.
- **Rounding:** pixel 127 at n=0 only, other pixels 0, LUT stub returning 512 for all entries. Each coefficient = (65024+512)>>10 = 64. With pixel -1 at n=0 only: (-512+512)>>10 = 0.
- **start while busy:** pulse start in C30. The sequence is unaffected and there is a single done.
- **Abort and reset:**
  - abort in C100 gives busy=0 in C101, no coeff_valid and no done. A new start then produces the full 64 coefficients.
  - rst_n low in C2000 asynchronously clears all outputs, the same cycle.
